// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//                - ILEN       : instruction word width
//                - INSTR_NOP  : canonical no-op encoding (addi x0,x0,0)
//                - fq_entry_t : {pc, instr} pair at the default address width
//                - sat_add32  : saturating 32-bit add for event counters
//  Revision    : 1.0  initial release
// ============================================================================
package if_pkg;

  localparam int ILEN      = 32;
  localparam int XLEN_DFLT = 32;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DFLT-1:0] pc;
    logic [ILEN-1:0]      instr;
  } fq_entry_t;

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_queue
//  Description : Synchronous FIFO holding fetched {pc, instr} entries.
//                Flush empties the queue and dominates push and pop.
//  Ports       : clk, rst        clock / async active-high reset
//                push, push_data write side
//                pop             consume head (ignored when empty)
//                flush           discard all entries
//                head            entry at the head of the queue
//                count/empty/full occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fq_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full queue is fine then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: head is only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch
//  Description : Instruction-fetch stage with a decoupled prefetch queue.
//                Issues in-order imem requests under a credit limit, buffers
//                {pc, instr} responses and hands them to decode via
//                valid/ready. A branch redirect flushes the queue and drops
//                every response still in flight.
//  Config      : IF_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
//  Ports       : clk, rst                        clock / async active-high reset
//                branch_taken, branch_target     redirect request
//                imem_req_valid/ready/addr       request channel
//                imem_rsp_valid/data             in-order response channel
//                dec_valid/ready/instr/pc        decode handshake
//                perf_fetch_cnt, perf_flush_cnt  (optional) event counters
//  Revision    : 1.0  initial release
// ============================================================================
module if_prefetch
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [ILEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int CW = $clog2(FQ_DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, tgt_aligned;
  logic [CW-1:0]   os_cnt_q, os_cnt_d, drop_cnt_q, drop_cnt_d, fq_count;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_drop, fq_push, fq_pop, fq_empty, fq_full;
  entry_t          fq_head, fq_wdata;
  logic [1:0]      unused_tgt_lsb;

  assign unused_tgt_lsb = branch_target[1:0];
  assign tgt_aligned    = {branch_target[XLEN-1:2], 2'b00};

  // Queued entries plus in-flight requests may never exceed the queue depth,
  // which is what makes an unconditional push on response safe.
  assign credit_used    = {1'b0, fq_count} + {1'b0, os_cnt_q};
  assign imem_req_valid = !rst && !branch_taken && (credit_used < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign os_cnt_d = os_cnt_q + CW'(req_fire) - CW'(imem_rsp_valid);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    rsp_drop   = 1'b0;
    if (imem_rsp_valid && (drop_cnt_q != '0)) begin
      rsp_drop   = 1'b1;
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
    // Everything still outstanding after this edge belongs to the old path.
    if (branch_taken) drop_cnt_d = os_cnt_d;
  end

  assign fq_push = imem_rsp_valid && !rsp_drop && !branch_taken;
  assign fq_pop  = dec_valid && dec_ready;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    if (branch_taken) begin
      pc_d     = tgt_aligned;
      rsp_pc_d = tgt_aligned;
    end else begin
      if (req_fire) pc_d     = pc_q + XLEN'(4);
      if (fq_push)  rsp_pc_d = rsp_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      os_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      os_cnt_q   <= os_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign fq_wdata.pc    = rsp_pc_q;
  assign fq_wdata.instr = imem_rsp_data;

  if_fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .T     (entry_t)
  ) u_fq (
    .clk       (clk),
    .rst       (rst),
    .push      (fq_push),
    .push_data (fq_wdata),
    .pop       (fq_pop),
    .flush     (branch_taken),
    .head      (fq_head),
    .count     (fq_count),
    .empty     (fq_empty),
    .full      (fq_full)
  );

  logic unused_fq_full;
  assign unused_fq_full = fq_full;

  assign dec_valid = !fq_empty;
  assign dec_instr = fq_empty ? '0 : fq_head.instr;
  assign dec_pc    = fq_empty ? '0 : fq_head.pc;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_flush_q, flush_inc;

  // Dropped responses (stale or arriving with the redirect) plus entries wiped by the flush.
  assign flush_inc = 32'(imem_rsp_valid && (rsp_drop || branch_taken))
                   + (branch_taken ? 32'(fq_count) : 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= sat_add32(perf_fetch_q, 32'(fq_push));
      perf_flush_q <= sat_add32(perf_flush_q, flush_inc);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
`default_nettype wire
